// File: rtl/seq_pipe_delay_if.sv
// Handshake, flush and observation bundle for seq_pipe_delay.
// master drives the pipeline inputs; slave is the pipeline itself.
interface seq_pipe_delay_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready;
    logic                   flush;
    logic [DEPTH-1:0]       tap_valid;
    logic [DEPTH*WIDTH-1:0] tap_data;
    logic [CW-1:0]          count;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, tap_valid, tap_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, tap_valid, tap_data, count
    );
endinterface

// File: rtl/seq_pipe_delay.sv
// Valid/ready delay pipeline of DEPTH stages with bubble collapsing, flush and taps.
// Define SEQ_PIPE_COUNTER_SRC_EN to feed stage 0 from an internal counter instead of in_data.
module seq_pipe_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);
    // Data only moves with a valid source so a bubble never overwrites held data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (adv) begin
            vld <= src_vld;
            if (src_vld) dat <= src_dat;
        end
    end
endmodule

module seq_pipe_delay #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    seq_pipe_delay_if.slave     bus
);
    localparam int CW = $clog2(DEPTH + 1);

    // Index 0 is the stage-0 source; index i+1 is stage i.
    logic [DEPTH:0]            vld_pipe;
    logic [DEPTH:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH-1:0]          adv;
    logic [WIDTH-1:0]          src_dat;
    logic                      in_xfer;
    logic                      out_xfer;
    logic [CW-1:0]             count_q;

    // A stage may advance if it is empty or everything after it advances.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = ~vld_pipe[DEPTH] | bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--)
            adv[i] = ~vld_pipe[i+1] | adv[i+1];
    end

    assign bus.in_ready = adv[0] & ~bus.flush;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = vld_pipe[DEPTH] & bus.out_ready;

`ifdef SEQ_PIPE_COUNTER_SRC_EN
    logic [WIDTH-1:0] src_cnt;
    logic             unused_in_data;

    assign unused_in_data = ^bus.in_data;

    // Flush leaves the sequence position alone; only reset restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          src_cnt <= '0;
        else if (in_xfer) src_cnt <= src_cnt + 1'b1;
    end

    assign src_dat = src_cnt;
`else
    assign src_dat = bus.in_data;
`endif

    assign vld_pipe[0] = in_xfer;
    assign dat_pipe[0] = src_dat;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        seq_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (bus.flush),
            .adv     (adv[g]),
            .src_vld (vld_pipe[g]),
            .src_dat (dat_pipe[g]),
            .vld     (vld_pipe[g+1]),
            .dat     (dat_pipe[g+1])
        );
        assign bus.tap_valid[g]                 = vld_pipe[g+1];
        assign bus.tap_data[g*WIDTH +: WIDTH]   = dat_pipe[g+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.out_valid = vld_pipe[DEPTH];
    assign bus.out_data  = dat_pipe[DEPTH];
endmodule

// File: tb/tb_seq_pipe_delay.sv
// Directed bench for seq_pipe_delay (WIDTH=4, DEPTH=3).
// Counter-source scenarios run when SEQ_PIPE_COUNTER_SRC_EN is defined.
module tb_seq_pipe_delay;
    localparam int WIDTH = 4;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_pipe_delay_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    seq_pipe_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #12;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_tap_valid", 32'(bus.tap_valid), 32'd0);
        rst = 1'b0;
        tick();

`ifdef SEQ_PIPE_COUNTER_SRC_EN
        begin
            int exp_val = 0;
            int got     = 0;
            int accepts = 0;
            for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
                bus.in_valid  = (accepts < 20) && (cyc % 7 != 4);
                bus.in_data   = 4'h9;
                bus.out_ready = (cyc % 5 != 3);
                #1;
                if (bus.out_valid && bus.out_ready) begin
                    chk("cnt_out_data", 32'(bus.out_data), 32'(exp_val));
                    exp_val = (exp_val + 1) % 16;
                    got++;
                end
                if (bus.in_valid && bus.in_ready) accepts++;
                tick();
            end
            chk("cnt_total_out", 32'(got), 32'd20);
        end
`else
        // Streaming 0..5 at full rate, then drain.
        for (int k = 0; k < 9; k++) begin
            bus.in_valid  = (k < 6);
            bus.in_data   = 4'(k);
            bus.out_ready = 1'b1;
            tick();
            chk("stream_out_valid", 32'(bus.out_valid), 32'((k >= 2) && (k <= 7)));
            if (k >= 2 && k <= 7)
                chk("stream_out_data", 32'(bus.out_data), 32'(k - 2));
            chk("stream_count", 32'(bus.count),
                32'((k <= 5) ? ((k + 1 < 3) ? k + 1 : 3) : 8 - k));
        end

        // Fill A,B,C with output stalled, then offer D.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 4'hA; tick();
        bus.in_data = 4'hB; tick();
        bus.in_data = 4'hC; tick();
        chk("full_count",     32'(bus.count),     32'd3);
        chk("full_tap_valid", 32'(bus.tap_valid), 32'h7);
        bus.in_data = 4'hD;
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("stall_count",    32'(bus.count),    32'd3);
        chk("stall_out_data", 32'(bus.out_data), 32'hA);
        chk("stall_taps",     32'(bus.tap_data), 32'hABC);
        bus.out_ready = 1'b1;
        #1;
        chk("pass_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("pass_out_data", 32'(bus.out_data), 32'hB);
        chk("pass_count",    32'(bus.count),    32'd3);
        chk("pass_taps",     32'(bus.tap_data), 32'hBCD);

        // Flush while full with input offered.
        bus.out_ready = 1'b0;
        bus.in_data   = 4'hE;
        bus.flush     = 1'b1;
        #1;
        chk("flush_in_ready",  32'(bus.in_ready),  32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_tap_valid", 32'(bus.tap_valid), 32'd0);
        chk("flush_count",     32'(bus.count),     32'd0);
        chk("flush_out_valid2",32'(bus.out_valid), 32'd0);
        chk("flush_taps_kept", 32'(bus.tap_data),  32'hBCD);

        // Consumer ready on an empty pipe changes nothing.
        bus.out_ready = 1'b1;
        tick();
        chk("empty_count",     32'(bus.count),     32'd0);
        chk("empty_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Bubble: A, gap, B with output stalled.
        bus.in_valid = 1'b1; bus.in_data = 4'h1; tick();
        bus.in_valid = 1'b0;                     tick();
        bus.in_valid = 1'b1; bus.in_data = 4'h2; tick();
        chk("bubble_tap_valid_a", 32'(bus.tap_valid), 32'b101);
        bus.in_valid = 1'b0;
        tick();
        chk("bubble_tap_valid_b", 32'(bus.tap_valid), 32'b110);
        chk("bubble_count",       32'(bus.count),     32'd2);
        chk("bubble_taps",        32'(bus.tap_data[11:4]), 32'h12);
        chk("bubble_out_data",    32'(bus.out_data),  32'h1);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  32'(bus.out_data),  32'd0);
        chk("arst_count",     32'(bus.count),     32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("arst_tap_valid", 32'(bus.tap_valid), 32'd0);
        #1;
        rst = 1'b0;

        // Restart stream after reset.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data = 4'h7; tick();
        bus.in_data = 4'h8; tick();
        bus.in_data = 4'h9; tick();
        chk("restart_out_valid", 32'(bus.out_valid), 32'd1);
        chk("restart_out_data",  32'(bus.out_data),  32'h7);
        chk("restart_count",     32'(bus.count),     32'd3);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_out_data", 32'(bus.out_data), 32'h8);
        chk("drain_count",    32'(bus.count),    32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
